// File: rtl/branch_jump_resolver_if.sv
// Issue/resolve bus between the issue stage and the branch/jump resolver.
interface branch_jump_resolver_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned REG_W = 5
);
  logic             new_jmp;
  logic [2:0]       jmp_type;
  logic [REG_W-1:0] jal_rs;
  logic [XLEN-1:0]  busJ;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  pc;
  logic [REG_W-1:0] rd;
  logic             rd_valid;
  logic             zero;
  logic             bit_bus_C;
  logic [XLEN-1:0]  newPC;
  logic             ctrlFetch;
  logic             halt;
  logic             reset_branch;
  logic             reset_jal;

  // Issue stage side
  modport master (
    output new_jmp, jmp_type, jal_rs, busJ, imm, pc, rd, rd_valid, zero, bit_bus_C,
    input  newPC, ctrlFetch, halt, reset_branch, reset_jal
  );

  // Resolver side
  modport slave (
    input  new_jmp, jmp_type, jal_rs, busJ, imm, pc, rd, rd_valid, zero, bit_bus_C,
    output newPC, ctrlFetch, halt, reset_branch, reset_jal
  );
endinterface

// File: rtl/branch_jump_resolver.sv
// Branch/jump resolution unit: in-flight branch queue, JAL/JALR redirect with
// rs hazard interlock, wrong-path squash and saturating perf counters.
module branch_jump_resolver #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RES_LAT   = 2,
  parameter int unsigned HAZ_DEPTH = 2,
  parameter int unsigned PC_ADJ    = 8,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  branch_jump_resolver_if.slave bus,
  output logic [CNT_W-1:0]     br_total,
  output logic [CNT_W-1:0]     br_taken,
  output logic [CNT_W-1:0]     halt_cycles
);

  localparam int unsigned TAIL = RES_LAT - 1;

  logic             q_v    [RES_LAT];
  logic [2:0]       q_type [RES_LAT];
  logic [XLEN-1:0]  q_tgt  [RES_LAT];
  logic [REG_W-1:0] hist   [HAZ_DEPTH];

  logic            is_br;
  logic            is_jal;
  logic            cond;
  logic            take;
  logic            any_v;
  logic            hazard;
  logic            halt_c;
  logic            jal_go;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jal_sum;
  logic [XLEN-1:0] jal_tgt;

  // Decode, tail resolution, interlock and redirect selection
  always_comb begin
    is_jal  = bus.new_jmp & (bus.jmp_type[2:1] == 2'b01);
    is_br   = bus.new_jmp & (bus.jmp_type[2:1] != 2'b01);

    case (q_type[TAIL])
      3'b000:         cond = bus.zero;
      3'b001:         cond = ~bus.zero;
      3'b100, 3'b110: cond = bus.bit_bus_C;
      3'b101, 3'b111: cond = ~bus.bit_bus_C;
      default:        cond = 1'b0;
    endcase
    take = reset & q_v[TAIL] & cond;

    any_v = 1'b0;
    for (int unsigned k = 0; k < RES_LAT; k++) any_v = any_v | q_v[k];

    hazard = 1'b0;
    for (int unsigned k = 0; k < HAZ_DEPTH; k++)
      if ((bus.jal_rs != '0) && (hist[k] == bus.jal_rs)) hazard = 1'b1;

    halt_c = reset & is_jal & (any_v | hazard);
    jal_go = reset & is_jal & ~halt_c & ~take;

    jal_sum = bus.imm + bus.busJ;
    jal_tgt = bus.jmp_type[0] ? {jal_sum[XLEN-1:1], 1'b0} : jal_sum;
    br_tgt  = bus.imm + bus.pc - XLEN'(PC_ADJ);

    bus.halt      = halt_c;
    bus.ctrlFetch = take | jal_go;
    if (!reset)      bus.newPC = '0;
    else if (take)   bus.newPC = q_tgt[TAIL];
    else if (jal_go) bus.newPC = jal_tgt;
    else             bus.newPC = q_tgt[TAIL];
  end

  // Queue shift, rd history, flush pulses and perf counters
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned k = 0; k < RES_LAT; k++) begin
        q_v[k]    <= 1'b0;
        q_type[k] <= 3'b000;
        q_tgt[k]  <= '0;
      end
      for (int unsigned k = 0; k < HAZ_DEPTH; k++) hist[k] <= '0;
      bus.reset_branch <= 1'b0;
      bus.reset_jal    <= 1'b0;
      br_total         <= '0;
      br_taken         <= '0;
      halt_cycles      <= '0;
    end else begin
      q_v[0]    <= is_br & ~halt_c & ~take;
      q_type[0] <= bus.jmp_type;
      q_tgt[0]  <= br_tgt;
      for (int unsigned k = 1; k < RES_LAT; k++) begin
        q_v[k]    <= q_v[k-1] & ~take;
        q_type[k] <= q_type[k-1];
        q_tgt[k]  <= q_tgt[k-1];
      end

      hist[0] <= (halt_c | ~bus.rd_valid | take) ? '0 : bus.rd;
      for (int unsigned k = 1; k < HAZ_DEPTH; k++)
        hist[k] <= take ? '0 : hist[k-1];

      bus.reset_branch <= take;
      bus.reset_jal    <= jal_go;

      if (q_v[TAIL] && (br_total != '1))   br_total    <= br_total + CNT_W'(1);
      if (take && (br_taken != '1))        br_taken    <= br_taken + CNT_W'(1);
      if (halt_c && (halt_cycles != '1))   halt_cycles <= halt_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_jump_resolver.sv
// Randomized + directed bench for branch_jump_resolver against a queue-based model.
module tb_branch_jump_resolver;

  localparam int unsigned RES_LAT   = 2;
  localparam int unsigned HAZ_DEPTH = 2;
  localparam int unsigned PC_ADJ    = 8;
  localparam int unsigned MAX16     = 65535;
  localparam int unsigned MAX2      = 3;

  logic        clock;
  logic        reset;
  logic        new_jmp;
  logic [2:0]  jmp_type;
  logic [4:0]  jal_rs;
  logic [31:0] busJ, imm, pc;
  logic [4:0]  rd;
  logic        rd_valid, zero, bit_bus_C;

  logic [15:0] br_total, br_taken, halt_cycles;
  logic [1:0]  s_total, s_taken, s_halt;

  branch_jump_resolver_if #(.XLEN(32), .REG_W(5)) bif ();
  branch_jump_resolver_if #(.XLEN(32), .REG_W(5)) sif ();

  assign bif.new_jmp = new_jmp;   assign sif.new_jmp = new_jmp;
  assign bif.jmp_type = jmp_type; assign sif.jmp_type = jmp_type;
  assign bif.jal_rs = jal_rs;     assign sif.jal_rs = jal_rs;
  assign bif.busJ = busJ;         assign sif.busJ = busJ;
  assign bif.imm = imm;           assign sif.imm = imm;
  assign bif.pc = pc;             assign sif.pc = pc;
  assign bif.rd = rd;             assign sif.rd = rd;
  assign bif.rd_valid = rd_valid; assign sif.rd_valid = rd_valid;
  assign bif.zero = zero;         assign sif.zero = zero;
  assign bif.bit_bus_C = bit_bus_C; assign sif.bit_bus_C = bit_bus_C;

  branch_jump_resolver #(.XLEN(32), .RES_LAT(RES_LAT), .HAZ_DEPTH(HAZ_DEPTH),
                         .PC_ADJ(PC_ADJ), .REG_W(5), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .bus(bif),
    .br_total(br_total), .br_taken(br_taken), .halt_cycles(halt_cycles));

  branch_jump_resolver #(.XLEN(32), .RES_LAT(RES_LAT), .HAZ_DEPTH(HAZ_DEPTH),
                         .PC_ADJ(PC_ADJ), .REG_W(5), .CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .bus(sif),
    .br_total(s_total), .br_taken(s_taken), .halt_cycles(s_halt));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state: in-flight branches and recent rd writes, stamped by cycle
  typedef struct { int unsigned issue; logic [2:0] ty; logic [31:0] tgt; } br_t;
  typedef struct { int unsigned cyc; logic [4:0] r; } rh_t;
  br_t bq[$];
  rh_t rh[$];
  int unsigned cyc = 0;
  int unsigned m_total = 0, m_taken = 0, m_halt = 0;
  logic        m_rb = 1'b0, m_rj = 1'b0;

  int unsigned n_cmp = 0, n_err = 0;
  logic        obs_fetch, obs_halt;
  logic [31:0] obs_newpc;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int unsigned sat(input int unsigned x, input int unsigned mx);
    return (x < mx) ? x + 1 : x;
  endfunction

  // One clock: check comb/registered outputs at negedge, then advance model at posedge
  task automatic step();
    logic        tail_ok, cnd, e_take, e_halt, e_go, is_jal, is_br, haz;
    logic [31:0] tail_tgt, jsum, e_pc;
    logic [2:0]  tty;
    @(negedge clock);
    tail_ok  = 1'b0;
    tail_tgt = 32'h0;
    tty      = 3'b010;
    if (bq.size() > 0 && bq[0].issue + RES_LAT == cyc) begin
      tail_ok  = 1'b1;
      tail_tgt = bq[0].tgt;
      tty      = bq[0].ty;
    end
    case (tty)
      3'b000:         cnd = zero;
      3'b001:         cnd = !zero;
      3'b100, 3'b110: cnd = bit_bus_C;
      3'b101, 3'b111: cnd = !bit_bus_C;
      default:        cnd = 1'b0;
    endcase
    e_take = reset && tail_ok && cnd;
    is_jal = reset && new_jmp && (jmp_type == 3'b010 || jmp_type == 3'b011);
    is_br  = reset && new_jmp && !(jmp_type == 3'b010 || jmp_type == 3'b011);
    haz = 1'b0;
    foreach (rh[i])
      if (rh[i].r != 0 && rh[i].r == jal_rs && cyc - rh[i].cyc <= HAZ_DEPTH) haz = 1'b1;
    e_halt = is_jal && (bq.size() > 0 || haz);
    e_go   = is_jal && !e_halt && !e_take;
    jsum   = imm + busJ;
    if (jmp_type == 3'b011) jsum = jsum & 32'hFFFF_FFFE;
    e_pc   = !reset ? 32'h0 : (e_take ? tail_tgt : jsum);

    obs_fetch = bif.ctrlFetch;
    obs_halt  = bif.halt;
    obs_newpc = bif.newPC;
    check_eq("halt", 32'(bif.halt), 32'(e_halt));
    check_eq("ctrlFetch", 32'(bif.ctrlFetch), 32'(e_take || e_go));
    if (e_take || e_go || !reset) check_eq("newPC", bif.newPC, e_pc);
    check_eq("reset_branch", 32'(bif.reset_branch), 32'(m_rb));
    check_eq("reset_jal", 32'(bif.reset_jal), 32'(m_rj));
    check_eq("br_total", 32'(br_total), (m_total < MAX16) ? m_total : MAX16);
    check_eq("br_taken", 32'(br_taken), (m_taken < MAX16) ? m_taken : MAX16);
    check_eq("halt_cycles", 32'(halt_cycles), (m_halt < MAX16) ? m_halt : MAX16);
    check_eq("sat_br_total", 32'(s_total), (m_total < MAX2) ? m_total : MAX2);
    check_eq("sat_br_taken", 32'(s_taken), (m_taken < MAX2) ? m_taken : MAX2);
    check_eq("sat_halt_cycles", 32'(s_halt), (m_halt < MAX2) ? m_halt : MAX2);

    @(posedge clock);
    if (!reset) begin
      bq.delete(); rh.delete();
      m_total = 0; m_taken = 0; m_halt = 0;
      m_rb = 1'b0; m_rj = 1'b0;
    end else begin
      if (tail_ok) begin
        m_total = sat(m_total, MAX16);
        void'(bq.pop_front());
      end
      if (e_take) begin
        m_taken = sat(m_taken, MAX16);
        bq.delete(); rh.delete();
      end
      if (e_halt) m_halt = sat(m_halt, MAX16);
      if (is_br && !e_halt && !e_take)
        bq.push_back('{issue: cyc, ty: jmp_type, tgt: imm + pc - 32'(PC_ADJ)});
      if (rd_valid && !e_halt && !e_take)
        rh.push_back('{cyc: cyc, r: rd});
      m_rb = e_take;
      m_rj = e_go;
    end
    cyc++;
    while (rh.size() > 0 && cyc - rh[0].cyc > HAZ_DEPTH) void'(rh.pop_front());
    #1;
  endtask

  task automatic drive(input logic nj, input logic [2:0] ty, input logic [31:0] pcv,
                       input logic [31:0] immv, input logic [31:0] bj, input logic [4:0] rs,
                       input logic [4:0] rdx, input logic rdv, input logic z, input logic c);
    new_jmp = nj; jmp_type = ty; pc = pcv; imm = immv; busJ = bj; jal_rs = rs;
    rd = rdx; rd_valid = rdv; zero = z; bit_bus_C = c;
    step();
  endtask

  task automatic idle(input logic z, input logic c);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, z, c);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    new_jmp = 1'b0; jmp_type = 3'b000; jal_rs = 5'd0; busJ = 32'h0; imm = 32'h0;
    pc = 32'h0; rd = 5'd0; rd_valid = 1'b0; zero = 1'b0; bit_bus_C = 1'b0;
    #1;
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check_eq("rst_newPC", obs_newpc, 32'h0);
    check_eq("rst_fetch", 32'(obs_fetch), 32'h0);
    reset = 1'b1;

    // BEQ taken: target pc+imm-8
    drive(1'b1, 3'b000, 32'h100, 32'h20, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    check_eq("t1_fetch", 32'(obs_fetch), 32'h1);
    check_eq("t1_newPC", obs_newpc, 32'h118);
    idle(1'b0, 1'b0);
    check_eq("t1_br_taken", 32'(br_taken), 32'h1);

    // BNE not taken
    do_reset();
    drive(1'b1, 3'b001, 32'h100, 32'h20, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    check_eq("t2_fetch", 32'(obs_fetch), 32'h0);
    idle(1'b0, 1'b0);
    check_eq("t2_br_total", 32'(br_total), 32'h1);
    check_eq("t2_br_taken", 32'(br_taken), 32'h0);

    // BLT in flight stalls JAL; replay once queue drains
    do_reset();
    drive(1'b1, 3'b100, 32'h300, 32'h40, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'b010, 32'h304, 32'h40, 32'h1000, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    check_eq("t3_halt", 32'(obs_halt), 32'h1);
    idle(1'b0, 1'b0);
    drive(1'b1, 3'b010, 32'h304, 32'h40, 32'h1000, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    check_eq("t3_fetch", 32'(obs_fetch), 32'h1);
    check_eq("t3_newPC", obs_newpc, 32'h1040);
    idle(1'b0, 1'b0);

    // JALR rs hazard against rd history
    do_reset();
    drive(1'b0, 3'b000, 32'h400, 32'h0, 32'h0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(1'b1, 3'b011, 32'h404, 32'h0, 32'h203, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0);
    check_eq("t4_fetch", 32'(obs_fetch), 32'h1);
    check_eq("t4_newPC", obs_newpc, 32'h202);
    idle(1'b0, 1'b0);
    check_eq("t4_halts", 32'(halt_cycles), 32'h2);

    // Taken branch squashes the younger one
    do_reset();
    drive(1'b1, 3'b000, 32'h200, 32'h10, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'b000, 32'h204, 32'h30, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    check_eq("t5_newPC", obs_newpc, 32'h208);
    idle(1'b1, 1'b0);
    check_eq("t5_squash", 32'(obs_fetch), 32'h0);
    idle(1'b0, 1'b0);
    check_eq("t5_br_total", 32'(br_total), 32'h1);

    // Reset discards queued branches
    do_reset();
    drive(1'b1, 3'b000, 32'h500, 32'h10, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'b000, 32'h504, 32'h10, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, 1'b0);
      check_eq("t6_no_fetch", 32'(obs_fetch), 32'h0);
    end
    check_eq("t6_br_total", 32'(br_total), 32'h0);

    // Saturation: six halts, 2-bit counter holds at 3
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'b000, 32'h600, 32'h0, 32'h0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 3'b011, 32'h604, 32'h0, 32'h80, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 3'b011, 32'h604, 32'h0, 32'h80, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    end
    idle(1'b0, 1'b0);
    check_eq("sat_halt", 32'(s_halt), 32'h3);
    check_eq("full_halt", 32'(halt_cycles), 32'h6);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] ty;
      reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 3) == 0) ty = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b011;
      else ty = 3'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 99) < 55), ty, $urandom, $urandom, $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    reset = 1'b1;
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
